// File: rtl/fetch_unit.sv
// Instruction fetch unit: predictor-steered PC, single outstanding memory read,
// and a small FIFO of fetched instructions feeding decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NO_PRED  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] laPC,
    input  logic [15:0] predAddr,
    output logic        memRen,
    output logic [15:0] memAddr,
    input  logic [15:0] memData,
    output logic        outValid,
    input  logic        outReady,
    output logic [15:0] outInstr,
    output logic [15:0] outPC,
    output logic [15:0] outPredTarget,
    output logic        outPredTaken,
    input  logic        redirect,
    input  logic [15:0] redirectPC
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [15:0]   laPC_q, laPC_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          infl_q;
    logic [15:0]   iPC_q, iTgt_q;
    logic          iTaken_q;

    logic [15:0] qInstr_q [DEPTH];
    logic [15:0] qPC_q    [DEPTH];
    logic [15:0] qTgt_q   [DEPTH];
    logic        qTaken_q [DEPTH];

    logic          predTaken;
    logic [15:0]   nextPC;
    logic [CW:0]   occ;
    logic          issue, enq, deq;

    assign predTaken = (predAddr != NO_PRED);
    assign nextPC    = predTaken ? predAddr : laPC_q + 16'd1;

    // Occupancy counts the in-flight read so a returning word always has a slot.
    assign occ   = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
    assign issue = !reset && !redirect && (occ < (CW+1)'(DEPTH));
    assign enq   = infl_q && !redirect;
    assign deq   = outValid && outReady;

    always_comb begin
        laPC_d = laPC_q;
        if (redirect)
            laPC_d = redirectPC;
        else if (issue)
            laPC_d = nextPC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            laPC_q   <= RESET_PC;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            infl_q   <= 1'b0;
            iPC_q    <= '0;
            iTgt_q   <= '0;
            iTaken_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                qInstr_q[i] <= '0;
                qPC_q[i]    <= '0;
                qTgt_q[i]   <= '0;
                qTaken_q[i] <= 1'b0;
            end
        end else begin
            laPC_q <= laPC_d;
            infl_q <= issue;
            if (issue) begin
                iPC_q    <= laPC_q;
                iTgt_q   <= nextPC;
                iTaken_q <= predTaken;
            end
            if (redirect) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (enq) begin
                    qInstr_q[wptr_q] <= memData;
                    qPC_q[wptr_q]    <= iPC_q;
                    qTgt_q[wptr_q]   <= iTgt_q;
                    qTaken_q[wptr_q] <= iTaken_q;
                    wptr_q           <= wptr_q + PW'(1);
                end
                if (deq)
                    rptr_q <= rptr_q + PW'(1);
                if (enq && !deq)
                    cnt_q <= cnt_q + CW'(1);
                else if (!enq && deq)
                    cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign laPC          = laPC_q;
    assign memRen        = issue;
    assign memAddr       = laPC_q;
    assign outValid      = (cnt_q != '0);
    assign outInstr      = qInstr_q[rptr_q];
    assign outPC         = qPC_q[rptr_q];
    assign outPredTarget = qTgt_q[rptr_q];
    assign outPredTaken  = qTaken_q[rptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, prediction, stall, redirect,
// PC wrap and mid-run reset, against a simple XOR-pattern instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] laPC, predAddr, memAddr, memData;
    logic        memRen, outValid, outReady, outPredTaken, redirect;
    logic [15:0] outInstr, outPC, outPredTarget, redirectPC;

    logic [15:0] pPC, pTgt;
    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .laPC(laPC), .predAddr(predAddr),
        .memRen(memRen), .memAddr(memAddr), .memData(memData),
        .outValid(outValid), .outReady(outReady), .outInstr(outInstr),
        .outPC(outPC), .outPredTarget(outPredTarget),
        .outPredTaken(outPredTaken), .redirect(redirect),
        .redirectPC(redirectPC)
    );

    always #5 clk = ~clk;

    // Predictor: one programmable PC/target pair.
    always_comb predAddr = (laPC == pPC) ? pTgt : 16'hFFFF;

    // Instruction memory: word = address XOR A5A5, one-cycle latency.
    initial memData = 16'h0000;
    always @(posedge clk) if (memRen) memData <= memAddr ^ 16'hA5A5;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] drain [6];

    initial begin
        reset = 1'b1; outReady = 1'b1; redirect = 1'b0;
        redirectPC = 16'h0000; pPC = 16'h0003; pTgt = 16'h0040;
        drain[0] = 16'h0003; drain[1] = 16'h0040; drain[2] = 16'h0041;
        drain[3] = 16'h0042; drain[4] = 16'h0043; drain[5] = 16'h0044;
        #2;
        chk("rst_laPC", laPC, 16'h0000);
        chk("rst_memRen", {15'd0, memRen}, 16'd0);
        chk("rst_outValid", {15'd0, outValid}, 16'd0);
        chk("rst_outInstr", outInstr, 16'h0000);
        chk("rst_outPC", outPC, 16'h0000);

        step(); reset = 1'b0; #1;
        chk("c0_memRen", {15'd0, memRen}, 16'd1);
        chk("c0_memAddr", memAddr, 16'h0000);
        chk("c0_outValid", {15'd0, outValid}, 16'd0);
        step();
        chk("c1_memAddr", memAddr, 16'h0001);
        chk("c1_outValid", {15'd0, outValid}, 16'd0);
        step();
        chk("c2_memAddr", memAddr, 16'h0002);
        chk("c2_outValid", {15'd0, outValid}, 16'd1);
        chk("c2_outPC", outPC, 16'h0000);
        chk("c2_outInstr", outInstr, 16'hA5A5);
        step();
        chk("c3_memAddr", memAddr, 16'h0003);
        chk("c3_outPC", outPC, 16'h0001);
        chk("c3_taken", {15'd0, outPredTaken}, 16'd0);
        chk("c3_target", outPredTarget, 16'h0002);
        step();
        pPC = 16'h9999;
        chk("c4_memAddr", memAddr, 16'h0040);
        chk("c4_outPC", outPC, 16'h0002);
        step();
        chk("c5_outPC", outPC, 16'h0003);
        chk("c5_taken", {15'd0, outPredTaken}, 16'd1);
        chk("c5_target", outPredTarget, 16'h0040);
        chk("c5_memAddr", memAddr, 16'h0041);

        outReady = 1'b0;
        repeat (10) step();
        chk("stall_memRen", {15'd0, memRen}, 16'd0);
        chk("stall_outPC", outPC, 16'h0003);
        chk("stall_outValid", {15'd0, outValid}, 16'd1);

        outReady = 1'b1; #1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_valid", {15'd0, outValid}, 16'd1);
            chk("drain_outPC", outPC, drain[i]);
            step();
        end

        redirect = 1'b1; redirectPC = 16'h0100; outReady = 1'b0; #1;
        chk("redir_memRen", {15'd0, memRen}, 16'd0);
        step(); redirect = 1'b0; outReady = 1'b1; #1;
        chk("redir_outValid", {15'd0, outValid}, 16'd0);
        chk("redir_memRen1", {15'd0, memRen}, 16'd1);
        chk("redir_memAddr", memAddr, 16'h0100);
        step();
        chk("redir_outValid2", {15'd0, outValid}, 16'd0);
        chk("redir_memAddr2", memAddr, 16'h0101);
        step();
        chk("redir_outValid3", {15'd0, outValid}, 16'd1);
        chk("redir_outPC", outPC, 16'h0100);
        chk("redir_outInstr", outInstr, 16'hA4A5);
        step();
        chk("redir_outPC2", outPC, 16'h0101);

        redirect = 1'b1; redirectPC = 16'hFFFE; outReady = 1'b0; #1;
        step(); redirect = 1'b0; #1;
        chk("wrap_memAddr0", memAddr, 16'hFFFE);
        step();
        chk("wrap_memAddr1", memAddr, 16'hFFFF);
        step();
        chk("wrap_memAddr2", memAddr, 16'h0000);
        chk("wrap_memRen", {15'd0, memRen}, 16'd1);
        step();
        step();
        chk("pre_rst_valid", {15'd0, outValid}, 16'd1);
        chk("pre_rst_outPC", outPC, 16'hFFFE);
        chk("pre_rst_memRen", {15'd0, memRen}, 16'd0);

        reset = 1'b1; #1;
        chk("mrst_outValid", {15'd0, outValid}, 16'd0);
        chk("mrst_memRen", {15'd0, memRen}, 16'd0);
        chk("mrst_laPC", laPC, 16'h0000);
        chk("mrst_outInstr", outInstr, 16'h0000);
        step(); reset = 1'b0; outReady = 1'b1; #1;
        chk("rel_memRen", {15'd0, memRen}, 16'd1);
        chk("rel_memAddr", memAddr, 16'h0000);
        step();
        chk("rel_outValid1", {15'd0, outValid}, 16'd0);
        step();
        chk("rel_outValid2", {15'd0, outValid}, 16'd1);
        chk("rel_outPC", outPC, 16'h0000);
        chk("rel_outInstr", outInstr, 16'hA5A5);
        chk("rel_memAddr2", memAddr, 16'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
